mem_copy_engine: RTL and testbench

- Block-copy initiator (DMA) that masters the data port of the segmented memory (six segments of RAMSIZE words, data addresses 0..RAMSIZE*6-1).
- Copies `len` consecutive words from `src` to `dst` over the single data port using a read, hold, write sequence per word.
- Sits beside the pipeline's MEM stage and owns the data port while `busy` is high; the top level muxes the port.

---
 rtl/mem_copy_engine.sv | 109 ++++++++++
 tb/tb_mem_copy_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// Block-copy DMA master for the segmented data memory: read, hold, write per word.
// Latency: CHECK 1 cycle, then 3 cycles per word; done pulses in cycle 3*len+2 after start.
// Backpressure: none; start is ignored while busy and the data port is owned until busy falls.
module mem_copy_engine #(
    parameter int WIDTH   = 32,
    parameter int RAMSIZE = 16,
    parameter int NSEG    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] mem_a,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int MEMWORDS = RAMSIZE * NSEG;
    localparam logic [WIDTH:0] MEM_LIMIT = (WIDTH+1)'(MEMWORDS);

    typedef enum logic [2:0] {IDLE, CHECK, RADDR, RDATA, WRITE, DONE, ERR} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] dst;
        logic [WIDTH-1:0] len;
    } req_t;

    state_t           state, state_nxt;
    req_t             req;
    logic [WIDTH-1:0] idx, idx_inc, rbuf;
    logic [WIDTH:0]   src_end, dst_end;

    // One extra bit so an out-of-range request can never wrap back into range.
    assign src_end = {1'b0, req.src} + {1'b0, req.len};
    assign dst_end = {1'b0, req.dst} + {1'b0, req.len};
    assign idx_inc = idx + WIDTH'(1);

    always_comb begin
        state_nxt = state;
        mem_a     = '0;
        mem_we    = 1'b0;
        mem_wd    = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CHECK;
            end
            CHECK: begin
                if (src_end > MEM_LIMIT || dst_end > MEM_LIMIT) state_nxt = ERR;
                else if (req.len == '0)                         state_nxt = DONE;
                else                                            state_nxt = RADDR;
            end
            RADDR: begin
                mem_a     = req.src + idx;
                state_nxt = RDATA;
            end
            RDATA: begin
                mem_a     = req.src + idx;
                state_nxt = WRITE;
            end
            WRITE: begin
                mem_a     = req.dst + idx;
                mem_we    = 1'b1;
                mem_wd    = rbuf;
                state_nxt = (idx_inc == req.len) ? DONE : RADDR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req   <= '0;
            idx   <= '0;
            rbuf  <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state_nxt == DONE);
            err   <= (state_nxt == ERR);
            if (state == IDLE && start) begin
                req   <= {src, dst, len};
                idx   <= '0;
                count <= '0;
            end
            // Read data has been stable for the whole RDATA cycle by this edge.
            if (state == RDATA) rbuf <= mem_rd;
            if (state == WRITE) begin
                idx   <= idx_inc;
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 96-word combinational-read memory model.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] src, dst, len;
    logic        busy, done, err, mem_we;
    logic [31:0] count, mem_a, mem_wd, mem_rd;

    mem_copy_engine #(.WIDTH(32), .RAMSIZE(16), .NSEG(6)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .err(err), .count(count),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:95];
    logic        init_mem = 1'b0;
    logic        pl_vld = 1'b0;
    logic [6:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < 96; k++) mem[k] <= 32'hA000_0000 + 32'(k);
        end else if (pl_vld) begin
            mem[pl_a] <= pl_d;
        end else if (mem_we && mem_a < 32'd96) begin
            mem[mem_a[6:0]] <= mem_wd;
        end
    end

    assign mem_rd = (mem_a < 32'd96) ? mem[mem_a[6:0]] : 32'h0;

    int errors = 0;
    int checks = 0;
    int done_cyc, err_cyc, end_cyc, we_cnt, done_cnt, err_cnt;
    logic [31:0] a_log [0:63];
    logic        we_log [0:63];

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_a = 7'(a); pl_d = d; pl_vld = 1'b1;
        @(negedge clk);
        pl_vld = 1'b0;
    endtask

    // Starts a copy and records per-cycle port activity; cycle 1 is the cycle after the start edge.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                            input int inj_cyc, input int rst_cyc);
        done_cyc = -1; err_cyc = -1; end_cyc = -1;
        we_cnt = 0; done_cnt = 0; err_cnt = 0;
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n < 64; n++) begin
            @(negedge clk);
            a_log[n]  = mem_a;
            we_log[n] = mem_we;
            if (mem_we) we_cnt++;
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = n; end
            if (err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = n;  end
            if (n == inj_cyc) begin start = 1'b1; src = 32'd0; dst = 32'd60; len = 32'd2; end
            else start = 1'b0;
            reset = (n == rst_cyc);
            if (!busy) begin end_cyc = n; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; src = 32'd3; dst = 32'd40; len = 32'd2; init_mem = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (mem_we !== 1'b0)  begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (count !== 32'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (mem_a !== 32'd0)  begin errors++; $display("FAIL reset_mem_a got %0d want 0", mem_a); end
        checks++; if (mem_wd !== 32'd0) begin errors++; $display("FAIL reset_mem_wd got %h want 0", mem_wd); end
        reset = 1'b0; start = 1'b0; init_mem = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic_copy();
        logic [31:0] exp_a;
        logic        exp_we;
        preload(0, 32'h11); preload(1, 32'h22); preload(2, 32'h33); preload(3, 32'h44);
        run_copy(32'd0, 32'd20, 32'd4, -1, -1);
        checks++; if (done_cyc !== 14) begin errors++; $display("FAIL basic_done_cycle got %0d want 14", done_cyc); end
        checks++; if (done_cnt !== 1)  begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
        checks++; if (end_cyc !== 15)  begin errors++; $display("FAIL basic_busy_fall got %0d want 15", end_cyc); end
        checks++; if (err_cnt !== 0)   begin errors++; $display("FAIL basic_err got %0d want 0", err_cnt); end
        checks++; if (count !== 32'd4) begin errors++; $display("FAIL basic_count got %0d want 4", count); end
        for (int n = 1; n <= 14; n++) begin
            exp_a = 32'd0; exp_we = 1'b0;
            if (n >= 2 && n <= 13) begin
                case ((n - 2) % 3)
                    0, 1:    exp_a = 32'((n - 2) / 3);
                    default: begin exp_a = 32'd20 + 32'((n - 2) / 3); exp_we = 1'b1; end
                endcase
            end
            checks++;
            if (a_log[n] !== exp_a || we_log[n] !== exp_we) begin
                errors++;
                $display("FAIL basic_port_c%0d got a=%0d we=%b want a=%0d we=%b", n, a_log[n], we_log[n], exp_a, exp_we);
            end
        end
        checks++; if (mem[20] !== 32'h11) begin errors++; $display("FAIL basic_mem20 got %h want 11", mem[20]); end
        checks++; if (mem[21] !== 32'h22) begin errors++; $display("FAIL basic_mem21 got %h want 22", mem[21]); end
        checks++; if (mem[22] !== 32'h33) begin errors++; $display("FAIL basic_mem22 got %h want 33", mem[22]); end
        checks++; if (mem[23] !== 32'h44) begin errors++; $display("FAIL basic_mem23 got %h want 44", mem[23]); end
    endtask

    task automatic test_cross_segment();
        run_copy(32'd14, 32'd46, 32'd4, -1, -1);
        checks++; if (done_cyc !== 14) begin errors++; $display("FAIL xseg_done_cycle got %0d want 14", done_cyc); end
        checks++; if (we_cnt !== 4)    begin errors++; $display("FAIL xseg_writes got %0d want 4", we_cnt); end
        checks++; if (a_log[11] !== 32'd17) begin errors++; $display("FAIL xseg_last_read got %0d want 17", a_log[11]); end
        checks++; if (a_log[13] !== 32'd49) begin errors++; $display("FAIL xseg_last_write got %0d want 49", a_log[13]); end
        checks++; if (mem[46] !== 32'hA000_000E) begin errors++; $display("FAIL xseg_mem46 got %h want a000000e", mem[46]); end
        checks++; if (mem[47] !== 32'hA000_000F) begin errors++; $display("FAIL xseg_mem47 got %h want a000000f", mem[47]); end
        checks++; if (mem[48] !== 32'hA000_0010) begin errors++; $display("FAIL xseg_mem48 got %h want a0000010", mem[48]); end
        checks++; if (mem[49] !== 32'hA000_0011) begin errors++; $display("FAIL xseg_mem49 got %h want a0000011", mem[49]); end
    endtask

    task automatic test_boundaries();
        run_copy(32'd5, 32'd10, 32'd0, -1, -1);
        checks++; if (done_cyc !== 2)  begin errors++; $display("FAIL len0_done_cycle got %0d want 2", done_cyc); end
        checks++; if (we_cnt !== 0)    begin errors++; $display("FAIL len0_writes got %0d want 0", we_cnt); end
        checks++; if (end_cyc !== 3)   begin errors++; $display("FAIL len0_busy_fall got %0d want 3", end_cyc); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL len0_count got %0d want 0", count); end
        run_copy(32'd0, 32'd95, 32'd1, -1, -1);
        checks++; if (done_cyc !== 5)  begin errors++; $display("FAIL top_done_cycle got %0d want 5", done_cyc); end
        checks++; if (we_cnt !== 1)    begin errors++; $display("FAIL top_writes got %0d want 1", we_cnt); end
        checks++; if (count !== 32'd1) begin errors++; $display("FAIL top_count got %0d want 1", count); end
        checks++; if (mem[95] !== 32'h11) begin errors++; $display("FAIL top_mem95 got %h want 11", mem[95]); end
    endtask

    task automatic test_range_error();
        run_copy(32'd90, 32'd0, 32'd7, -1, -1);
        checks++; if (err_cyc !== 2)   begin errors++; $display("FAIL rng_err_cycle got %0d want 2", err_cyc); end
        checks++; if (err_cnt !== 1)   begin errors++; $display("FAIL rng_err_pulses got %0d want 1", err_cnt); end
        checks++; if (done_cnt !== 0)  begin errors++; $display("FAIL rng_done got %0d want 0", done_cnt); end
        checks++; if (we_cnt !== 0)    begin errors++; $display("FAIL rng_writes got %0d want 0", we_cnt); end
        checks++; if (end_cyc !== 3)   begin errors++; $display("FAIL rng_busy_fall got %0d want 3", end_cyc); end
        checks++; if (count !== 32'd0) begin errors++; $display("FAIL rng_count got %0d want 0", count); end
        run_copy(32'd0, 32'hFFFF_FFFF, 32'd2, -1, -1);
        checks++; if (err_cyc !== 2)   begin errors++; $display("FAIL wrap_err_cycle got %0d want 2", err_cyc); end
        checks++; if (done_cnt !== 0)  begin errors++; $display("FAIL wrap_done got %0d want 0", done_cnt); end
        checks++; if (we_cnt !== 0)    begin errors++; $display("FAIL wrap_writes got %0d want 0", we_cnt); end
        checks++; if (mem[0] !== 32'h11) begin errors++; $display("FAIL wrap_mem0 got %h want 11", mem[0]); end
    endtask

    task automatic test_ignore_start();
        run_copy(32'd4, 32'd30, 32'd3, 3, -1);
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL ign_done_cycle got %0d want 11", done_cyc); end
        checks++; if (end_cyc !== 12)  begin errors++; $display("FAIL ign_busy_fall got %0d want 12", end_cyc); end
        checks++; if (we_cnt !== 3)    begin errors++; $display("FAIL ign_writes got %0d want 3", we_cnt); end
        checks++; if (count !== 32'd3) begin errors++; $display("FAIL ign_count got %0d want 3", count); end
        checks++; if (mem[30] !== 32'hA000_0004) begin errors++; $display("FAIL ign_mem30 got %h want a0000004", mem[30]); end
        checks++; if (mem[32] !== 32'hA000_0006) begin errors++; $display("FAIL ign_mem32 got %h want a0000006", mem[32]); end
        checks++; if (mem[60] !== 32'hA000_003C) begin errors++; $display("FAIL ign_mem60 got %h want a000003c", mem[60]); end
        @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL ign_no_queue got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_copy();
        run_copy(32'd0, 32'd70, 32'd5, -1, 8);
        checks++; if (end_cyc !== 9)    begin errors++; $display("FAIL rstmid_busy_fall got %0d want 9", end_cyc); end
        checks++; if (we_log[9] !== 1'b0) begin errors++; $display("FAIL rstmid_we_after got %b want 0", we_log[9]); end
        checks++; if (we_cnt !== 2)     begin errors++; $display("FAIL rstmid_writes got %0d want 2", we_cnt); end
        checks++; if (done_cnt !== 0)   begin errors++; $display("FAIL rstmid_done got %0d want 0", done_cnt); end
        checks++; if (count !== 32'd0)  begin errors++; $display("FAIL rstmid_count got %0d want 0", count); end
        checks++; if (mem[70] !== 32'h11) begin errors++; $display("FAIL rstmid_mem70 got %h want 11", mem[70]); end
        checks++; if (mem[71] !== 32'h22) begin errors++; $display("FAIL rstmid_mem71 got %h want 22", mem[71]); end
        checks++; if (mem[72] !== 32'hA000_0048) begin errors++; $display("FAIL rstmid_mem72 got %h want a0000048", mem[72]); end
        @(negedge clk);
        checks++; if (mem_we !== 1'b0)  begin errors++; $display("FAIL rstmid_we_idle got %b want 0", mem_we); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_cross_segment();
        test_boundaries();
        test_range_error();
        test_ignore_start();
        test_reset_mid_copy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
